// File: rtl/hamming_secded_pkg.sv
// Shared types and helpers for the SECDED UART receive path.
package hamming_secded_pkg;
    // Hamming positions (1-based); codeword bit index is position - 1, bit 7 is overall parity.
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D0 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D1 = 5;
    localparam int POS_D2 = 6;
    localparam int POS_D3 = 7;
    localparam int IDX_PAR = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic err1;
        logic err2;
        logic par;
    } dec_status_t;

    function automatic logic [2:0] hamming84_syndrome(input logic [7:0] cw);
        logic [2:0] s;
        s[0] = cw[POS_P1-1] ^ cw[POS_D0-1] ^ cw[POS_D1-1] ^ cw[POS_D3-1];
        s[1] = cw[POS_P2-1] ^ cw[POS_D0-1] ^ cw[POS_D2-1] ^ cw[POS_D3-1];
        s[2] = cw[POS_P4-1] ^ cw[POS_D1-1] ^ cw[POS_D2-1] ^ cw[POS_D3-1];
        return s;
    endfunction
endpackage

// File: rtl/hamming84_decode.sv
// Combinational extended Hamming(8,4) decoder: correct single errors, flag double/parity errors.
module hamming84_decode
    import hamming_secded_pkg::*;
(
    input  logic [7:0]  i_cw,
    output logic [3:0]  o_data,
    output dec_status_t o_status
);
    logic [2:0] w_syn;
    logic       w_q;
    logic [7:0] w_fix;

    always_comb begin
        w_syn    = hamming84_syndrome(i_cw);
        w_q      = ^i_cw;
        w_fix    = i_cw;
        o_status = '0;
        if (w_syn != 3'd0 && w_q) begin
            w_fix[w_syn - 3'd1] = ~i_cw[w_syn - 3'd1];
            o_status.err1       = 1'b1;
        end else if (w_syn == 3'd0 && w_q) begin
            o_status.par = 1'b1;
        end else if (w_syn != 3'd0) begin
            // Two flips: syndrome points nowhere useful, so data stays raw.
            o_status.err2 = 1'b1;
        end
        o_data = {w_fix[POS_D3-1], w_fix[POS_D2-1], w_fix[POS_D1-1], w_fix[POS_D0-1]};
    end
endmodule

// File: rtl/hamming_secded_uart_rx.sv
// UART receiver for SECDED codewords with a single-entry output buffer and error counters.
module hamming_secded_uart_rx
    import hamming_secded_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    input  logic             i_ready,
    input  logic             i_clr_cnt,
    output logic             o_valid,
    output logic [3:0]       o_data,
    output logic             o_1bit_error,
    output logic             o_2bit_error,
    output logic             o_parity_error,
    output logic             o_frame_error,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_cnt_corrected,
    output logic [CNT_W-1:0] o_cnt_uncorrectable
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              r_sync1, r_sync2;
    rx_state_e         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_cw;
    logic              r_valid;
    logic [3:0]        r_data;
    dec_status_t       r_status;
    logic              r_ferr, r_ovr;
    logic [CNT_W-1:0]  r_cnt_corr, r_cnt_unc;

    logic              w_rx, w_stop_smp, w_push, w_accept;
    logic [3:0]        w_dec_data;
    dec_status_t       w_dec_status;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_cw    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (!w_rx) begin
                    r_state <= ST_START;
                    r_baud  <= '0;
                end
                ST_START: if (r_baud == HALF_LAST) begin
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_state <= w_rx ? ST_IDLE : ST_DATA;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                ST_DATA: if (r_baud == FULL_LAST) begin
                    r_baud <= '0;
                    r_cw   <= {w_rx, r_cw[7:1]};
                    r_bit  <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_state <= ST_STOP;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                ST_STOP: if (r_baud == FULL_LAST) begin
                    r_baud  <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    hamming84_decode u_dec (
        .i_cw     (r_cw),
        .o_data   (w_dec_data),
        .o_status (w_dec_status)
    );

    assign w_stop_smp = (r_state == ST_STOP) && (r_baud == FULL_LAST);
    assign w_push     = w_stop_smp && w_rx;
    // A push into a full buffer still lands if the consumer drains it this cycle.
    assign w_accept   = w_push && (!r_valid || i_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_status   <= '0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else begin
            r_ferr <= w_stop_smp && !w_rx;
            r_ovr  <= w_push && !w_accept;
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_data   <= w_dec_data;
                r_status <= w_dec_status;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_clr_cnt) begin
                r_cnt_corr <= '0;
                r_cnt_unc  <= '0;
            end else if (w_accept) begin
                if ((w_dec_status.err1 || w_dec_status.par) && r_cnt_corr != '1)
                    r_cnt_corr <= r_cnt_corr + 1'b1;
                if (w_dec_status.err2 && r_cnt_unc != '1)
                    r_cnt_unc <= r_cnt_unc + 1'b1;
            end
        end
    end

    assign o_valid             = r_valid;
    assign o_data              = r_data;
    assign o_1bit_error        = r_status.err1;
    assign o_2bit_error        = r_status.err2;
    assign o_parity_error      = r_status.par;
    assign o_frame_error       = r_ferr;
    assign o_overrun           = r_ovr;
    assign o_cnt_corrected     = r_cnt_corr;
    assign o_cnt_uncorrectable = r_cnt_unc;
endmodule

// File: tb/tb_hamming_secded_uart_rx.sv
// Bench for hamming_secded_uart_rx: directed vectors, random codewords with injected errors, corner sequences.
module tb_hamming_secded_uart_rx;
    localparam int CPB = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rdy = 1'b0, clr = 1'b0;
    logic          o_valid, o_1bit_error, o_2bit_error, o_parity_error, o_frame_error, o_overrun;
    logic [3:0]    o_data;
    logic [CW-1:0] o_cnt_corrected, o_cnt_uncorrectable;

    hamming_secded_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_ready(rdy), .i_clr_cnt(clr),
        .o_valid(o_valid), .o_data(o_data), .o_1bit_error(o_1bit_error),
        .o_2bit_error(o_2bit_error), .o_parity_error(o_parity_error),
        .o_frame_error(o_frame_error), .o_overrun(o_overrun),
        .o_cnt_corrected(o_cnt_corrected), .o_cnt_uncorrectable(o_cnt_uncorrectable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cw;
        logic [3:0] data;
        logic       e1, e2, par;
    } vec_t;

    int         n_tests = 0, n_fail = 0;
    int         m_corr = 0, m_unc = 0;
    int         fe_cnt = 0, ov_cnt = 0;
    logic [6:0] got[$];
    vec_t       vecs[8];

    // Every word the consumer takes, plus pulse-cycle counts.
    always @(negedge clk) begin
        if (o_valid && rdy) got.push_back({o_1bit_error, o_2bit_error, o_parity_error, o_data});
        if (o_frame_error) fe_cnt++;
        if (o_overrun) ov_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d required completion", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] cw, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = cw[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] pos;
        logic [7:0] cw;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int p = 1; p <= 4; p = p * 2)
            for (int j = 3; j < 8; j++)
                if (j != 4 && (j & p) != 0) pos[p] = pos[p] ^ pos[j];
        cw = '0;
        for (int k = 1; k <= 7; k++) cw[k-1] = pos[k];
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    // Reference decode: syndrome is the XOR of the positions of all set bits.
    task automatic model_decode(input logic [7:0] cw, output logic [3:0] d,
                                output logic e1, output logic e2, output logic par);
        int         s;
        logic       q;
        logic [7:0] fx;
        s  = 0;
        for (int k = 1; k <= 7; k++) if (cw[k-1]) s = s ^ k;
        q  = ^cw;
        fx = cw;
        e1 = (s != 0) && q;
        par = (s == 0) && q;
        e2 = (s != 0) && !q;
        if (e1) fx[s-1] = ~fx[s-1];
        d = {fx[6], fx[5], fx[4], fx[2]};
    endtask

    task automatic expect_word(input string nm, input logic [3:0] d, input logic e1,
                               input logic e2, input logic par, input bit chk_cnt);
        logic [6:0] w;
        for (int i = 0; i < 300 && got.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (got.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no output word within 300 cycles, required %0h", nm, {e1, e2, par, d});
            return;
        end
        w = got.pop_front();
        chk(nm, 32'(w), 32'({e1, e2, par, d}));
        if (e1 || par) m_corr = (m_corr < SAT) ? m_corr + 1 : SAT;
        if (e2) m_unc = (m_unc < SAT) ? m_unc + 1 : SAT;
        if (chk_cnt) begin
            chk({nm, "_cnt_corr"}, 32'(o_cnt_corrected), 32'(m_corr));
            chk({nm, "_cnt_unc"}, 32'(o_cnt_uncorrectable), 32'(m_unc));
        end
    endtask

    initial begin
        logic [7:0] cw, cw2;
        logic [3:0] d, d2;
        logic       e1, e2, pr, f1, f2, fp;
        int         fe0, ov0, b1, b2, nf;

        vecs[0] = '{8'hD2, 4'hA, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hC2, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h52, 4'hA, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hD1, 4'hA, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hD6, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 4'h0, 1'b0, 1'b0, 1'b1};

        repeat (3) tick();
        chk("rst_valid", 32'(o_valid), 32'(0));
        chk("rst_data", 32'(o_data), 32'(0));
        chk("rst_flags", 32'({o_1bit_error, o_2bit_error, o_parity_error, o_frame_error, o_overrun}), 32'(0));
        chk("rst_cnts", 32'({o_cnt_corrected, o_cnt_uncorrectable}), 32'(0));
        rst_n = 1'b1;
        rdy   = 1'b1;
        repeat (4) tick();

        foreach (vecs[i]) begin
            send_frame(vecs[i].cw, 1'b1);
            expect_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].e1, vecs[i].e2, vecs[i].par, 1'b1);
            tick();
        end

        // Back-to-back frames with a one-bit stop.
        d  = 4'(($urandom));
        d2 = 4'(($urandom));
        cw  = encode(d);
        cw2 = encode(d2) ^ 8'h10;
        send_frame(cw, 1'b1);
        send_frame(cw2, 1'b1);
        model_decode(cw, d, e1, e2, pr);
        expect_word("b2b_a", d, e1, e2, pr, 1'b0);
        model_decode(cw2, d2, f1, f2, fp);
        expect_word("b2b_b", d2, f1, f2, fp, 1'b1);
        tick();

        for (int it = 0; it < 60; it++) begin
            cw = encode(4'($urandom));
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            if (nf >= 1) cw[b1] = ~cw[b1];
            if (nf == 2) cw[b2] = ~cw[b2];
            model_decode(cw, d, e1, e2, pr);
            send_frame(cw, 1'b1);
            expect_word($sformatf("rand%0d_cw%02h", it, cw), d, e1, e2, pr, 1'b1);
            tick();
        end

        for (int it = 0; it < SAT + 2; it++) begin
            send_frame(8'hD1, 1'b1);
            expect_word("sat_unc", 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("unc_saturated", 32'(o_cnt_uncorrectable), 32'(SAT));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_corr = 0;
        m_unc  = 0;
        chk("clr_corr", 32'(o_cnt_corrected), 32'(0));
        chk("clr_unc", 32'(o_cnt_uncorrectable), 32'(0));

        // Clear held across an accepted 1-bit-error push: clear must win.
        clr = 1'b1;
        send_frame(8'hC2, 1'b1);
        expect_word("clr_wins_word", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        m_corr = 0;
        chk("clr_wins_corr", 32'(o_cnt_corrected), 32'(0));
        clr = 1'b0;
        tick();

        fe0 = fe_cnt;
        send_frame(8'hD2, 1'b0);
        repeat (20) tick();
        chk("ferr_pulse", 32'(fe_cnt - fe0), 32'(1));
        chk("ferr_noword", 32'(got.size()), 32'(0));
        chk("ferr_valid", 32'(o_valid), 32'(0));

        fe0 = fe_cnt;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (30) tick();
        chk("glitch_noword", 32'(got.size()), 32'(0));
        chk("glitch_noferr", 32'(fe_cnt - fe0), 32'(0));

        rdy = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'hD2, 1'b1);
        repeat (6) tick();
        chk("hold_valid", 32'(o_valid), 32'(1));
        chk("hold_data", 32'(o_data), 32'(4'hA));
        send_frame(8'h00, 1'b1);
        repeat (6) tick();
        chk("ovr_once", 32'(ov_cnt - ov0), 32'(1));
        chk("ovr_data_kept", 32'({o_valid, o_data}), 32'({1'b1, 4'hA}));
        send_frame(8'hC2, 1'b1);
        repeat (6) tick();
        chk("ovr_twice", 32'(ov_cnt - ov0), 32'(2));
        chk("ovr_cnt_corr", 32'(o_cnt_corrected), 32'(m_corr));
        rdy = 1'b1;
        expect_word("ovr_drain", 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) tick();
        chk("ovr_only_one", 32'(got.size()), 32'(0));
        chk("ovr_valid_low", 32'(o_valid), 32'(0));

        // Reset in the middle of DATA with a word already buffered.
        rdy = 1'b0;
        send_frame(8'hD1, 1'b1);
        repeat (4) tick();
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        rx = 1'b0;
        repeat (CPB) tick();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) tick();
        m_corr = 0;
        m_unc  = 0;
        chk("mrst_valid", 32'(o_valid), 32'(0));
        chk("mrst_data_flags", 32'({o_data, o_1bit_error, o_2bit_error, o_parity_error}), 32'(0));
        chk("mrst_cnts", 32'({o_cnt_corrected, o_cnt_uncorrectable}), 32'(0));
        rst_n = 1'b1;
        rdy   = 1'b1;
        repeat (4) tick();
        send_frame(8'hD2, 1'b1);
        expect_word("post_rst", 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
